// File: rtl/shift_normalizer.sv
// Iterative normaliser: left-justifies a word (mode 0 leading zeros, mode 1 redundant sign bits).
// Latency: done on the cycle after the (shamt+2)-th edge counted from the start-sampling edge.
// Backpressure: none; start is ignored while busy or done, and results hold until the next run.
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] shamt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SGN  = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [CNT_W-1:0] cnt_q;
  logic             m_q;
  logic             term;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Sign mode stops one shift early so the sign bit always survives.
  always_comb begin
    state_d = state_q;
    term    = 1'b0;
    if (m_q) term = (work_q[WIDTH-1] != work_q[WIDTH-2]) || (cnt_q == CNT_SGN);
    else     term = work_q[WIDTH-1] || (cnt_q == CNT_MAX);
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (term) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= CNT_ZERO;
      m_q    <= 1'b0;
      out    <= '0;
      shamt  <= CNT_ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            work_q <= in;
            m_q    <= mode;
            cnt_q  <= CNT_ZERO;
          end
        end
        RUN: begin
          if (term) begin
            out   <= work_q;
            shamt <= cnt_q;
          end else begin
            work_q <= work_q << 1;
            cnt_q  <= cnt_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: directed vectors push expectations, a monitor checks on done.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [31:0] dout;
  logic [5:0]  shamt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [31:0] out;
    logic [5:0]  shamt;
    int          issue;
  } exp_t;

  exp_t exp_q[$];

  shift_normalizer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .in    (din),
    .busy  (busy),
    .done  (done),
    .out   (dout),
    .shamt (shamt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out", 64'(dout), 64'(e.out));
          chk("shamt", 64'(shamt), 64'(e.shamt));
          chk("latency", 64'(cyc - e.issue), 64'(e.shamt) + 64'd2);
          chk("busy_cycles", 64'(busy_cnt), 64'(e.shamt) + 64'd1);
          chk("busy_in_done", 64'(busy), 64'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  // hold=1 keeps start high (with a different operand) until done is seen.
  task automatic run_op(input logic md, input logic [31:0] d,
                        input logic [31:0] eo, input logic [5:0] es, input bit hold);
    exp_t e;
    int   n;
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    din   = d;
    e.out = eo;
    e.shamt = es;
    e.issue = cyc;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (hold) begin
        din  = 32'h0000_0001;
        mode = 1'b1;
      end else begin
        start = 1'b0;
      end
    end while (!done && n < 100);
    start = 1'b0;
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic        md;
    logic [31:0] d;
    logic [31:0] eo;
    logic [5:0]  es;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    din   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(dout), 64'd0);
    chk("rst_shamt", 64'(shamt), 64'd0);
    rst_n = 1'b1;

    vecs.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 6'd0});
    vecs.push_back('{1'b0, 32'h0000_0001, 32'h8000_0000, 6'd31});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 6'd32});
    vecs.push_back('{1'b1, 32'hFFFF_8000, 32'h8000_0000, 6'd16});
    vecs.push_back('{1'b1, 32'h0000_1234, 32'h48D0_0000, 6'd18});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 6'd31});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0000, 6'd31});
    vecs.push_back('{1'b0, 32'h0001_0000, 32'h8000_0000, 6'd15});
    vecs.push_back('{1'b0, 32'h1234_5678, 32'h91A2_B3C0, 6'd3});
    vecs.push_back('{1'b1, 32'h4000_0000, 32'h4000_0000, 6'd0});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h8000_0000, 6'd0});
    vecs.push_back('{1'b1, 32'h0000_0001, 32'h4000_0000, 6'd30});
    vecs.push_back('{1'b1, 32'hC000_0000, 32'h8000_0000, 6'd1});
    vecs.push_back('{1'b1, 32'h3FFF_FFFF, 32'h7FFF_FFFE, 6'd1});

    foreach (vecs[i]) run_op(vecs[i].md, vecs[i].d, vecs[i].eo, vecs[i].es, 1'b0);

    // start held through RUN and DONE with a new operand: only the first run reports.
    run_op(1'b0, 32'h0F00_0000, 32'hF000_0000, 6'd4, 1'b1);
    repeat (40) @(negedge clk);
    chk("idle_after_held_start", 64'(busy), 64'd0);

    // Reset mid-run: outputs clear and no done follows.
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    din   = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_mid_run", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out", 64'(dout), 64'd0);
    chk("abort_shamt", 64'(shamt), 64'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    run_op(1'b0, 32'h0000_0100, 32'h8000_0000, 6'd23, 1'b0);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
